// File: rtl/mae_arb_pkg.sv
// Shared widths and the tag-stage type for the MAE round-robin arbiter.
package mae_arb_pkg;

  localparam int unsigned MAE_AW   = 18;
  localparam int unsigned MAE_CW   = 40;
  localparam int unsigned MAE_PW   = 40;
  localparam int unsigned LAT_MAX  = 3;
  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned TAG_IW   = 3;

  // One slot of the result-routing pipeline: valid bit plus owning requester.
  typedef struct packed {
    logic              v;
    logic [TAG_IW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mae_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, with wrap.
module mae_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int unsigned   sum;
  logic [IW-1:0] pos;
  logic          found;

  // Scan NREQ positions starting at ptr; the first requesting one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = 0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = 32'(ptr_i) + i;
      // ptr < NREQ, so one subtraction is enough to wrap
      pos = IW'((sum >= NREQ) ? (sum - NREQ) : sum);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mae_rr_arbiter.sv
// Round-robin sharing of one MAE among NREQ requesters, with a tag pipeline
// that routes each result on mae_p back to the requester that issued it.
module mae_rr_arbiter
  import mae_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MAE_AW-1:0] req_a,
  input  logic [NREQ*MAE_AW-1:0] req_b,
  input  logic [NREQ*MAE_CW-1:0] req_c,
  output logic [MAE_AW-1:0]      mae_a,
  output logic [MAE_AW-1:0]      mae_b,
  output logic [MAE_CW-1:0]      mae_c,
  input  logic [MAE_PW-1:0]      mae_p,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [MAE_PW-1:0]      rsp_p,
  output logic [1:0]             inflight,
  output logic                   idle
);

  localparam int unsigned IW  = $clog2(NREQ);
  // Keep at least one stage declared so LAT = 0 still elaborates; it is never observed then.
  localparam int unsigned NST = (LAT == 0) ? 1 : LAT;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   gnt_idx;
  logic            pick_any;
  logic            grant;
  tag_t            tag_in;
  tag_t            stage_q [NST];

  assign cand = hold ? '0 : req_valid;

  mae_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (cand),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (gnt_idx),
    .any_o (pick_any)
  );

  // No grants while reset is held, even though ptr is already at 0.
  assign grant     = pick_any & resetn;
  assign req_ready = pick_gnt & {NREQ{resetn}};

  // Advance the pointer past the winner; hold it when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Operand mux: winner's operands, zero when idle to keep MAE inputs quiet.
  always_comb begin
    mae_a = '0;
    mae_b = '0;
    mae_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        mae_a = req_a[i*MAE_AW +: MAE_AW];
        mae_b = req_b[i*MAE_AW +: MAE_AW];
        mae_c = req_c[i*MAE_CW +: MAE_CW];
      end
    end
  end

  assign tag_in = '{v: grant, id: TAG_IW'(gnt_idx)};

  // Tag pipeline: shifts every cycle, mirroring the MAE's fixed latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NST; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned k = 1; k < NST; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  // Response strobe from the last tag stage, or straight from the grant when LAT = 0.
  always_comb begin
    rsp_valid = '0;
    if (LAT == 0) begin
      rsp_valid = req_ready;
    end else if (stage_q[NST-1].v) begin
      rsp_valid[stage_q[NST-1].id[IW-1:0]] = 1'b1;
    end
  end

  assign rsp_p = mae_p;

  // Count of live tags across the pipeline.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < LAT; k++) begin
      inflight = inflight + {1'b0, stage_q[k].v};
    end
  end

  assign idle = !grant && (inflight == 2'd0);

endmodule
